// File: rtl/deparser_layer_pkg.sv
// deparser_layer_pkg: widths, rule entry layout and conf word selects shared by the deparser layer.
package deparser_layer_pkg;
  localparam int HEAD_WIDTH = 512;
  localparam int META_WIDTH = 512;
  localparam int TAG_WIDTH = 8;
  localparam int RULE_NUM = 8;
  localparam int KEY_FIELD_NUM = 4;
  localparam int KEY_FIELD_WIDTH = 16;
  localparam int KEY_OFFSET_WIDTH = 5;
  localparam int SHIFT_WIDTH = 6;
  localparam int HW = HEAD_WIDTH + TAG_WIDTH;
  localparam int MW = META_WIDTH + TAG_WIDTH;
  localparam int UNITS = HEAD_WIDTH / KEY_FIELD_WIDTH;
  localparam logic [2:0] SEL_W0 = 3'd0;
  localparam logic [2:0] SEL_W1 = 3'd1;
  typedef logic [KEY_OFFSET_WIDTH:0] key_off_t;
  typedef struct packed {
    logic valid;
    logic [SHIFT_WIDTH-1:0] head_shift;
    logic [SHIFT_WIDTH-1:0] meta_shift;
    key_off_t [KEY_FIELD_NUM-1:0] key_off;
  } rule_t;
endpackage

// File: rtl/deparser_layer_if.sv
// deparser_layer_if: conf port plus header/meta stream of one deparser layer.
interface deparser_layer_if;
  import deparser_layer_pkg::*;
  logic i_rule_wren;
  logic i_rule_rden;
  logic [31:0] i_rule_addr;
  logic [31:0] i_rule_wdata;
  logic o_rule_rdata_valid;
  logic [31:0] o_rule_rdata;
  logic i_valid;
  logic o_ready;
  logic [HW-1:0] i_head;
  logic [MW-1:0] i_meta;
  logic o_valid;
  logic i_ready;
  logic [HW-1:0] o_head;
  logic [MW-1:0] o_meta;
  logic [15:0] o_miss_cnt;
  modport slave (
    input i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata, i_valid, i_head, i_meta, i_ready,
    output o_rule_rdata_valid, o_rule_rdata, o_ready, o_valid, o_head, o_meta, o_miss_cnt
  );
  modport master (
    output i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata, i_valid, i_head, i_meta, i_ready,
    input o_rule_rdata_valid, o_rule_rdata, o_ready, o_valid, o_head, o_meta, o_miss_cnt
  );
endinterface

// File: rtl/deparser_layer_rule_table.sv
// deparser_layer_rule_table: per-layer rule storage, conf-port write decode and registered readback.
module deparser_layer_rule_table
  import deparser_layer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wren_i,
  input  logic        rden_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rdata_valid_o,
  output logic [31:0] rdata_o,
  input  logic [2:0]  idx_i,
  output rule_t       rule_o
);
  rule_t [RULE_NUM-1:0] tbl_q;
  rule_t rd_rule;
  logic [2:0] ridx, sel;
  logic [31:0] word;
  logic rdata_valid_q;
  logic [31:0] rdata_q;
  logic unused;
  assign unused = ^{addr_i[31:7], addr_i[3], wdata_i[30:24]};
  assign ridx = addr_i[6:4];
  assign sel = addr_i[2:0];
  assign rd_rule = tbl_q[ridx];
  assign word = sel == SEL_W0 ? {rd_rule.valid, 17'd0, rd_rule.head_shift, 2'd0, rd_rule.meta_shift}
              : sel == SEL_W1 ? {8'd0, rd_rule.key_off} : 32'd0;
  assign rule_o = tbl_q[idx_i];
  assign rdata_valid_o = rdata_valid_q;
  assign rdata_o = rdata_q;
  // readback samples the table before this edge's write, so a colliding read sees the old word
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_q <= '0;
      rdata_valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdata_valid_q <= rden_i;
      if (rden_i) rdata_q <= word;
      if (wren_i && sel == SEL_W0) begin
        tbl_q[ridx].valid <= wdata_i[31];
        tbl_q[ridx].head_shift <= wdata_i[13:8];
        tbl_q[ridx].meta_shift <= wdata_i[5:0];
      end
      if (wren_i && sel == SEL_W1) tbl_q[ridx].key_off <= wdata_i[23:0];
    end
  end
endmodule

// File: rtl/deparser_layer.sv
// deparser_layer: egress stage that pops key fields off meta and writes them back into a shifted header.
// Define DEPARSER_PIPE_REG_EN to register the looked-up beat before shift/insert (latency 2).
module deparser_layer
  import deparser_layer_pkg::*;
(
  input logic i_clk,
  input logic i_rst,
  deparser_layer_if.slave bus
);
  rule_t lk_rule, src_rule;
  logic [HW-1:0] src_head, head_d, head_q;
  logic [MW-1:0] src_meta, meta_d, meta_q;
  logic [UNITS-1:0][KEY_FIELD_WIDTH-1:0] hu;
  logic [0:KEY_FIELD_NUM-1][KEY_FIELD_WIDTH-1:0] fld;
  logic valid_q, accept, adv, load, hit, miss;
  logic [15:0] miss_q;
  deparser_layer_rule_table u_tbl (
    .clk(i_clk), .rst(i_rst),
    .wren_i(bus.i_rule_wren), .rden_i(bus.i_rule_rden),
    .addr_i(bus.i_rule_addr), .wdata_i(bus.i_rule_wdata),
    .rdata_valid_o(bus.o_rule_rdata_valid), .rdata_o(bus.o_rule_rdata),
    .idx_i(bus.i_head[2:0]), .rule_o(lk_rule)
  );
  assign adv = !valid_q | bus.i_ready;
`ifdef DEPARSER_PIPE_REG_EN
  logic s1_valid_q;
  logic [HW-1:0] s1_head_q;
  logic [MW-1:0] s1_meta_q;
  rule_t s1_rule_q;
  assign bus.o_ready = !s1_valid_q | adv;
  assign accept = bus.i_valid & bus.o_ready;
  assign load = s1_valid_q & adv;
  assign src_head = s1_head_q;
  assign src_meta = s1_meta_q;
  assign src_rule = s1_rule_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) s1_valid_q <= 1'b0;
    else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_head_q <= bus.i_head;
      s1_meta_q <= bus.i_meta;
      s1_rule_q <= lk_rule;
    end else if (adv) s1_valid_q <= 1'b0;
  end
`else
  assign bus.o_ready = adv;
  assign accept = bus.i_valid & adv;
  assign load = accept;
  assign src_head = bus.i_head;
  assign src_meta = bus.i_meta;
  assign src_rule = lk_rule;
`endif
  assign fld = src_meta[MW-1 -: KEY_FIELD_NUM*KEY_FIELD_WIDTH];
  assign hit = src_head[TAG_WIDTH-1] & src_rule.valid;
  assign miss = src_head[TAG_WIDTH-1] & !src_rule.valid;
  // unit u sits at payload index UNITS-1-u, i.e. the bitwise inverse of the 5-bit offset
  always_comb begin
    hu = src_head[HW-1:TAG_WIDTH] >> {src_rule.head_shift, 3'b000};
    for (int k = 0; k < KEY_FIELD_NUM; k++)
      if (src_rule.key_off[k][KEY_OFFSET_WIDTH]) hu[~src_rule.key_off[k][KEY_OFFSET_WIDTH-1:0]] = fld[k];
    head_d = hit ? {hu, src_head[TAG_WIDTH-1:0]} : src_head;
    meta_d = hit ? {src_meta[MW-1:TAG_WIDTH] << {src_rule.meta_shift, 3'b000}, src_meta[TAG_WIDTH-1:0]} : src_meta;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      head_q <= '0;
      meta_q <= '0;
      miss_q <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      head_q <= head_d;
      meta_q <= meta_d;
      if (miss && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end else if (bus.i_ready) valid_q <= 1'b0;
  end
  assign bus.o_valid = valid_q;
  assign bus.o_head = head_q;
  assign bus.o_meta = meta_q;
  assign bus.o_miss_cnt = miss_q;
endmodule

// File: tb/tb_deparser_layer.sv
// tb_deparser_layer: randomized and directed checks of deparser_layer against a behavioural model.
module tb_deparser_layer;
  import deparser_layer_pkg::*;
`ifdef DEPARSER_PIPE_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  deparser_layer_if bus();
  deparser_layer dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_chk = 0, n_pass = 0;
  bit m_val [8];
  int m_hs [8];
  int m_ms [8];
  bit m_ov [8][4];
  int m_off [8][4];
  int m_miss = 0;
  logic [519:0] q_head [$];
  logic [519:0] q_meta [$];

  task automatic chk(input string nm, input logic [519:0] got, input logic [519:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  function automatic logic [519:0] rnd();
    logic [519:0] v = '0;
    for (int i = 0; i < 17; i++) v = {v[487:0], 32'($urandom)};
    return v;
  endfunction

  function automatic void model(input logic [519:0] h, input logic [519:0] m,
                                output logic [519:0] eh, output logic [519:0] em);
    int i;
    logic [511:0] hp, mp;
    i = int'(h[2:0]);
    eh = h;
    em = m;
    if (h[7] && m_val[i]) begin
      hp = h[519:8] >> (8 * m_hs[i]);
      mp = m[519:8] << (8 * m_ms[i]);
      eh = {hp, h[7:0]};
      em = {mp, m[7:0]};
      for (int k = 0; k < 4; k++)
        if (m_ov[i][k]) eh[519 - 16 * m_off[i][k] -: 16] = m[519 - 16 * k -: 16];
    end
  endfunction

  always @(negedge clk) begin
    logic [519:0] eh, em;
    if (bus.o_valid) begin
      if (q_head.size() == 0) chk("o_valid_spurious", bus.o_valid, 0);
      else begin
        chk("o_head", bus.o_head, q_head[0]);
        chk("o_meta", bus.o_meta, q_meta[0]);
        if (bus.i_ready) begin
          void'(q_head.pop_front());
          void'(q_meta.pop_front());
        end
      end
    end
`ifndef DEPARSER_PIPE_REG_EN
    else if (q_head.size() != 0) chk("o_valid_missing", bus.o_valid, 1);
    chk("o_miss_cnt", bus.o_miss_cnt, m_miss);
    chk("o_ready", bus.o_ready, !bus.o_valid | bus.i_ready);
`endif
    if (rst) begin
      q_head.delete();
      q_meta.delete();
      m_miss = 0;
      foreach (m_val[i]) m_val[i] = 0;
    end else if (bus.i_valid && bus.o_ready) begin
      model(bus.i_head, bus.i_meta, eh, em);
      q_head.push_back(eh);
      q_meta.push_back(em);
      if (bus.i_head[7] && !m_val[bus.i_head[2:0]] && m_miss < 65535) m_miss++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [2:0] sel, input logic [31:0] d);
    bus.i_rule_wren = 1'b1;
    bus.i_rule_addr = {25'd0, idx, 1'b0, sel};
    bus.i_rule_wdata = d;
    step();
    bus.i_rule_wren = 1'b0;
  endtask

  task automatic set_rule(input logic [2:0] idx, input bit v, input logic [5:0] hs,
                          input logic [5:0] ms, input logic [23:0] ko);
    wr(idx, 3'd0, {v, 17'd0, hs, 2'd0, ms});
    wr(idx, 3'd1, {8'd0, ko});
    m_val[idx] = v;
    m_hs[idx] = int'(hs);
    m_ms[idx] = int'(ms);
    for (int k = 0; k < 4; k++) begin
      m_ov[idx][k] = ko[6 * k + 5];
      m_off[idx][k] = int'(ko[6 * k +: 5]);
    end
  endtask

  task automatic rd(input logic [2:0] idx, input logic [2:0] sel, input logic [31:0] exp, input string nm);
    bus.i_rule_rden = 1'b1;
    bus.i_rule_addr = {25'd0, idx, 1'b0, sel};
    step();
    bus.i_rule_rden = 1'b0;
    chk({nm, "_vld"}, bus.o_rule_rdata_valid, 1);
    chk(nm, bus.o_rule_rdata, exp);
  endtask

  task automatic send(input logic [519:0] h, input logic [519:0] m);
    int n = 0;
    bit acc;
    bus.i_valid = 1'b1;
    bus.i_head = h;
    bus.i_meta = m;
    do begin
      @(negedge clk);
      acc = bus.o_ready;
      step();
      n++;
    end while (!acc && n < 50);
    bus.i_valid = 1'b0;
    if (!acc) chk("send_timeout_o_ready", bus.o_ready, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.o_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [519:0] h, m, hold_h, hold_m;
    int lat, acc;
    bus.i_rule_wren = 0;
    bus.i_rule_rden = 0;
    bus.i_rule_addr = '0;
    bus.i_rule_wdata = '0;
    bus.i_valid = 0;
    bus.i_head = '0;
    bus.i_meta = '0;
    bus.i_ready = 1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_head", bus.o_head, 0);
    chk("rst_o_meta", bus.o_meta, 0);
    chk("rst_o_miss_cnt", bus.o_miss_cnt, 0);
    chk("rst_rdata_valid", bus.o_rule_rdata_valid, 0);
    chk("rst_rdata", bus.o_rule_rdata, 0);
    step();
    // directed rule 2: head shift 14 B, meta shift 8 B, field0 -> unit6, field1 -> unit0
    set_rule(3'd2, 1'b1, 6'd14, 6'd8, {6'd0, 6'd0, 6'b100000, 6'b100110});
    h = {16'hCAFE, 480'h0, 16'h1357, 8'h82};
    m = {64'h0800_AABB_CCDD_EEFF, 64'h1234_5678_9ABC_DEF0, 384'h0, 8'h00};
    send(h, m);
    wait_out(lat);
    chk("t1_latency", lat, LAT);
    chk("t1_unit6", bus.o_head[519 - 96 -: 16], 16'h0800);
    chk("t1_unit0", bus.o_head[519 -: 16], 16'hAABB);
    chk("t1_unit7", bus.o_head[519 - 112 -: 16], 16'hCAFE);
    chk("t1_unit3", bus.o_head[519 - 48 -: 16], 16'h0000);
    chk("t1_tag", bus.o_head[7:0], 8'h82);
    chk("t1_meta", bus.o_meta, {64'h1234_5678_9ABC_DEF0, 448'h0, 8'h00});
    // overlapping writes: field1 lands last on unit3
    set_rule(3'd1, 1'b1, 6'd0, 6'd0, {6'd0, 6'd0, 6'b100011, 6'b100011});
    h = rnd();
    h[7:0] = 8'h81;
    send(h, {16'h1111, 16'h2222, 480'h0, 8'h00});
    wait_out(lat);
    chk("t4_unit3", bus.o_head[519 - 48 -: 16], 16'h2222);
    chk("t4_unit0", bus.o_head[519 -: 16], h[519 -: 16]);
    step();
    // conf readback: colliding read/write, unused selects
    set_rule(3'd4, 1'b1, 6'd5, 6'd7, 24'h0);
    bus.i_rule_wren = 1'b1;
    bus.i_rule_rden = 1'b1;
    bus.i_rule_addr = {25'd0, 3'd4, 1'b0, 3'd0};
    bus.i_rule_wdata = 32'h0000_0A03;
    step();
    bus.i_rule_wren = 1'b0;
    bus.i_rule_rden = 1'b0;
    m_val[4] = 0;
    m_hs[4] = 10;
    m_ms[4] = 3;
    chk("t5_collide_old", bus.o_rule_rdata, 32'h8000_0507);
    rd(3'd4, 3'd0, 32'h0000_0A03, "t5_new_w0");
    set_rule(3'd3, 1'b1, 6'd1, 6'd1, 24'hABCDEF);
    wr(3'd3, 3'd5, 32'hFFFF_FFFF);
    rd(3'd3, 3'd1, 32'h00AB_CDEF, "t5_w1");
    rd(3'd3, 3'd0, 32'h8000_0101, "t5_w0_after_ignored");
    rd(3'd3, 3'd7, 32'h0, "t5_w7");
    // randomized traffic over random rules
    for (int i = 0; i < 8; i++)
      set_rule(3'(i), ($urandom % 4) != 0, 6'($urandom), 6'($urandom), 24'($urandom));
    for (int c = 0; c < 1500; c++) begin
      bus.i_valid = ($urandom % 4) != 0;
      bus.i_ready = ($urandom % 4) != 0;
      h = rnd();
      h[7] = ($urandom % 8) != 0;
      bus.i_head = h;
      bus.i_meta = rnd();
      step();
    end
    bus.i_valid = 0;
    bus.i_ready = 1;
    repeat (4) step();
    // backpressure: output held for 5 clk while a second beat waits
    bus.i_ready = 0;
    h = rnd();
    h[7:0] = 8'h82;
    send(h, rnd());
    wait_out(lat);
    chk("t2_latency", lat, LAT);
    hold_h = bus.o_head;
    hold_m = bus.o_meta;
    bus.i_valid = 1;
    bus.i_head = rnd();
    bus.i_meta = rnd();
    repeat (5) begin
      step();
      chk("t2_o_ready", bus.o_ready, 0);
      chk("t2_o_valid", bus.o_valid, 1);
      chk("t2_hold_head", bus.o_head, hold_h);
      chk("t2_hold_meta", bus.o_meta, hold_m);
    end
    bus.i_ready = 1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      bus.i_head = rnd();
      bus.i_meta = rnd();
      @(negedge clk);
      if (bus.o_ready) acc++;
      step();
    end
    chk("t2_back_to_back", acc, 10);
    bus.i_valid = 0;
    repeat (4) step();
    // miss counter saturation through an invalid rule
    set_rule(3'd5, 1'b0, 6'd0, 6'd0, 24'h0);
    h = rnd();
    h[7:0] = 8'h85;
    bus.i_head = h;
    bus.i_meta = rnd();
    bus.i_valid = 1;
    repeat (70000) step();
    bus.i_valid = 0;
    repeat (3) step();
    chk("t3_miss_sat", bus.o_miss_cnt, 16'hFFFF);
    chk("t3_passthrough", bus.o_head, h);
    // reset with a beat held at the output
    bus.i_ready = 0;
    h = rnd();
    h[7:0] = 8'h82;
    send(h, rnd());
    wait_out(lat);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_o_valid", bus.o_valid, 0);
    chk("t6_miss_cnt", bus.o_miss_cnt, 0);
    chk("t6_o_head", bus.o_head, 0);
    rd(3'd2, 3'd0, 32'h0, "t6_rule2_w0");
    bus.i_ready = 1;
    send(h, m);
    wait_out(lat);
    chk("t6_passthrough", bus.o_head, h);
    chk("t6_miss_after", bus.o_miss_cnt, 1);
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
